// File: rtl/mux5_arb_pkg.sv
// Shared constants and types for the five-way round-robin arbiter
// that drives the select of a shared mux5 datapath.
package mux5_arb_pkg;
    localparam int NREQ  = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_CIN1 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_CIN2 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_CIN3 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_CIN4 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_CIN5 = 3'd4;

    // With last at 4 the search begins at requester 0.
    localparam logic [SEL_W-1:0] RESET_LAST = 3'd4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;
endpackage

// File: rtl/mux5_rr_arbiter_rr_pick5.sv
// Combinational round-robin pick: the first set candidate bit found
// scanning upward from last+1, wrapping 4 -> 0.
module rr_pick5
    import mux5_arb_pkg::*;
(
    input  logic [NREQ-1:0]  cand,
    input  logic [SEL_W-1:0] last,
    output logic [NREQ-1:0]  win,
    output logic [SEL_W-1:0] idx,
    output logic             any_valid
);
    logic [3:0]       pos;
    logic [SEL_W-1:0] probe;

    // Scanning from the farthest offset back to the nearest lets the
    // nearest set bit overwrite the others.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        pos       = '0;
        probe     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = {1'b0, last} + 4'(k);
            if (pos >= 4'(NREQ)) begin
                pos = pos - 4'(NREQ);
            end
            probe = pos[SEL_W-1:0];
            if (cand[probe]) begin
                idx       = probe;
                any_valid = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_win
            assign win[gi] = any_valid & (idx == SEL_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/mux5_rr_arbiter.sv
// Five-requester round-robin arbiter: registered one-hot grant and
// mux5 select, valid/ready towards the consumer, done pulse on accept.
module mux5_rr_arbiter #(
    parameter int NREQ  = 5,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             out_ready,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [NREQ-1:0]  done
);
    import mux5_arb_pkg::*;

    generate
        if (NREQ != 5 || SEL_W != 3) begin : g_bad_param
            $error("mux5_rr_arbiter supports only NREQ=5, SEL_W=3");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] last_reg, last_next;
    logic             out_valid_reg, out_valid_next;

    logic [NREQ-1:0]  pick_cand;
    logic [SEL_W-1:0] pick_last;
    logic [NREQ-1:0]  pick_win;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             winner_held;

    rr_pick5 u_pick (
        .cand      (pick_cand),
        .last      (pick_last),
        .win       (pick_win),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // A granted requester that drops req before accept aborts the transfer.
    assign winner_held = |(req & gnt_reg);

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        out_valid_next = out_valid_reg;
        pick_cand      = req;
        pick_last      = last_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    gnt_next       = pick_win;
                    sel_next       = pick_idx;
                    out_valid_next = 1'b1;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                // Current winner is masked and becomes the new search origin.
                pick_cand = req & ~gnt_reg;
                pick_last = sel_reg;
                if (!winner_held) begin
                    last_next      = sel_reg;
                    gnt_next       = '0;
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end else if (out_ready) begin
                    last_next = sel_reg;
                    if (pick_any) begin
                        gnt_next = pick_win;
                        sel_next = pick_idx;
                    end else begin
                        gnt_next       = '0;
                        out_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            sel_reg       <= SEL_CIN1;
            last_reg      <= RESET_LAST;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            sel_reg       <= sel_next;
            last_reg      <= last_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign gnt       = gnt_reg;
    assign sel       = sel_reg;
    assign out_valid = out_valid_reg;
    assign done      = gnt_reg & {NREQ{out_ready & winner_held & ~rst}};
endmodule

// File: doc/mux5_rr_arbiter.md
Name: mux5_rr_arbiter

Overview:
- Round-robin arbiter that shares one mux5 datapath port between five requesters.
- Grants one requester at a time and drives the 3-bit select of the downstream mux5 (000..100 selects cin1..cin5).
- Presents a valid/ready handshake to the consumer of the mux output.
- Sits between the requesting units (e.g. memory/writeback sources) and the shared result bus.

Parameters:
- NREQ, 5, number of requesters; fixed at 5. Any other value is unsupported and is a synthesis-time error.
- SEL_W, 3, width of the mux select.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req  input  5  req[i] = requester i has data on mux input cin(i+1); held until done[i]
- out_ready  input  1  consumer accepts the mux output this cycle
- gnt  output  5  one-hot registered grant; all zero when idle
- sel  output  3  registered mux5 select; equals the index of the granted requester
- out_valid  output  1  mux output valid (registered); asserted iff gnt != 0
- done  output  5  combinational one-cycle pulse, done[i] = gnt[i] & out_ready

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: gnt=0, sel=3'b000, out_valid=0, done=0, state=IDLE, internal pointer last=3'd4. With last=4, requester 0 has top priority after reset.
- Priority order: search starts at (last+1) mod 5 and wraps 4->0. The first set bit of the candidate vector wins.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0: register gnt/sel for the winner, set out_valid=1, go to GRANT.
  - Latency is one cycle: req asserted in cycle n gives gnt/out_valid in cycle n+1.
  - Else: stay in IDLE; sel holds its last value.
- GRANT, accept (out_ready=1):
  - done[winner]=1 this cycle; last <= winner.
  - Re-arbitrate in the same cycle with candidate = req & ~gnt, so the current winner is masked for this decision only.
  - If candidate != 0: load the new winner, stay in GRANT. Back-to-back transfers have no bubble.
  - Else: clear gnt and out_valid, go to IDLE.
- GRANT, stall (out_ready=0):
  - Hold gnt, sel and out_valid unchanged; done=0.
  - Stalls are indefinite; there is no timeout.
- GRANT, abort (req[winner]=0 before accept): protocol violation, handled as an abort.
  - Next cycle: gnt=0, out_valid=0, state IDLE; no done pulse.
  - last <= winner, so the aborting requester loses its turn.
  - Abort takes precedence over out_ready in the same cycle: the out_ready is ignored and done stays 0.
- Requester reuse: after done[i], requester i may keep req[i] high to mean a new transfer. It then competes at lowest priority from the next cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - sel == index(gnt) whenever out_valid=1.
  - sel never takes 101..111.
- Fairness: with all five requesting continuously and out_ready=1, grants rotate 0,1,2,3,4,0,... Each requester is served once per 5 transfers.
- Reset mid-operation (rst in any state): next cycle all outputs are at reset values and the pending transfer is dropped with no done pulse. rst takes priority over every other input.

Decomposition:
- Package mux5_arb_pkg:
  - NREQ=5, SEL_W=3
  - select constants SEL_CIN1..SEL_CIN5 = 3'd0..3'd4
  - state enum {IDLE, GRANT}
  - RESET_LAST=3'd4
- Sub-module rr_pick5: purely combinational. Inputs are the 5-bit candidate and the 3-bit last pointer. Outputs are the one-hot winner, the 3-bit index and any_valid. It is reused for both IDLE and accept-cycle arbitration.

Test Plan:
- Reset then req=5'b00001, out_ready=1 -> cycle+1: gnt=00001, sel=000, out_valid=1, done=00001; cycle+2: idle if req dropped.
- req=5'b11111 held, out_ready=1 for 10 cycles -> sel sequence 0,1,2,3,4,0,1,2,3,4, no idle bubbles, exactly one done bit per cycle.
- req=5'b10100, out_ready=0 for 4 cycles then 1 -> gnt=00100/sel=010 stable for 4 cycles; on accept done=00100 and next gnt=10000/sel=100.
- Grant requester 3 (sel=011), then drop req[3] with out_ready=0 -> next cycle gnt=0, out_valid=0, no done; a later req=01001 grants requester 0 (pointer advanced past 3).
- Wrap-around: last=4 after serving requester 4, req=5'b10001 -> requester 0 wins (sel=000).
- rst asserted while in GRANT with out_ready=1 -> next cycle gnt=0, sel=000, out_valid=0, done=0; first grant after reset goes to the lowest set index.
